// File: rtl/gpio_arb_pkg.sv
// Shared types and constants for the gpio register-port arbiter.
package gpio_arb_pkg;

  // Arbiter lock state: IDLE rotates grants, LOCKED pins the grant to one owner.
  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_e;

  // Position of the write flag inside an emesh packet.
  localparam int unsigned WRITE_BIT = 0;

  // Cycles from acceptance to the read-data strobe on rsp_valid/rsp_data.
  localparam int unsigned RD_LAT = 3;

endpackage

// File: rtl/gpio_rr_pick.sv
// Circular priority picker: first requester at or after i_ptr, wrapping at NR.
module gpio_rr_pick #(
  parameter int unsigned NR  = 2,
  parameter int unsigned IDW = 3
) (
  input  logic [NR-1:0]  i_req,
  input  logic [IDW-1:0] i_ptr,
  output logic [NR-1:0]  o_grant,
  output logic [IDW-1:0] o_idx
);

  logic [NR-1:0] w_rot;
  logic          w_found;
  logic [IDW:0]  w_sum;

  // Rotate requests so bit 0 is the pointer slot, take the first set bit,
  // then map the rotated position back to a master index.
  always_comb begin
    w_rot   = NR'({i_req, i_req} >> i_ptr);
    w_found = 1'b0;
    w_sum   = '0;
    o_idx   = '0;
    for (int unsigned k = 0; k < NR; k++) begin
      if (!w_found && w_rot[k]) begin
        w_found = 1'b1;
        w_sum   = {1'b0, i_ptr} + (IDW+1)'(k);
        if (w_sum >= (IDW+1)'(NR)) begin
          w_sum = w_sum - (IDW+1)'(NR);
        end
        o_idx = w_sum[IDW-1:0];
      end
    end
    o_grant = '0;
    for (int unsigned i = 0; i < NR; i++) begin
      o_grant[i] = w_found && (o_idx == IDW'(i));
    end
  end

endmodule

// File: rtl/gpio_reg_arb.sv
// Round-robin arbiter with per-master lock feeding the gpio register port,
// returning read data to the issuing master RD_LAT cycles after acceptance.
module gpio_reg_arb
  import gpio_arb_pkg::*;
#(
  parameter int unsigned NR  = 2,
  parameter int unsigned AW  = 32,
  parameter int unsigned PW  = 2*AW+40,
  parameter int unsigned IDW = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NR-1:0]    req_access,
  input  logic [NR-1:0]    req_lock,
  input  logic [NR*PW-1:0] req_packet,
  output logic [NR-1:0]    req_wait,
  output logic [NR-1:0]    rsp_valid,
  output logic [31:0]      rsp_data,
  output logic             gpio_access,
  output logic [PW-1:0]    gpio_packet,
  input  logic [31:0]      gpio_rdata
);

  localparam int unsigned RET_DEPTH = RD_LAT - 1;

  arb_state_e     r_state;
  arb_state_e     w_state_nxt;
  logic [IDW-1:0] r_owner;
  logic [IDW-1:0] w_owner_nxt;
  logic [IDW-1:0] r_rr_ptr;
  logic [IDW-1:0] w_rr_ptr_nxt;

  logic [NR-1:0]  w_pick_grant;
  logic [IDW-1:0] w_pick_idx;
  logic [NR-1:0]  w_grant;
  logic [IDW-1:0] w_idx;
  logic [IDW-1:0] w_idx_inc;
  logic           w_accept;
  logic [PW-1:0]  w_acc_packet;
  logic           w_acc_lock;

  logic           r_ret_rd  [RET_DEPTH];
  logic [IDW-1:0] r_ret_idx [RET_DEPTH];
  logic [NR-1:0]  w_rsp_onehot;

  gpio_rr_pick #(
    .NR  (NR),
    .IDW (IDW)
  ) u_pick (
    .i_req   (req_access),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_pick_grant),
    .o_idx   (w_pick_idx)
  );

  // Grant selection, accepted-packet mux, lock FSM next state and rr pointer.
  always_comb begin
    w_state_nxt  = r_state;
    w_owner_nxt  = r_owner;
    w_rr_ptr_nxt = r_rr_ptr;
    w_grant      = '0;
    w_idx        = w_pick_idx;
    w_acc_packet = '0;
    w_acc_lock   = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_grant = w_pick_grant;
        w_idx   = w_pick_idx;
      end
      ST_LOCKED: begin
        w_idx = r_owner;
        for (int unsigned i = 0; i < NR; i++) begin
          if (r_owner == IDW'(i)) begin
            w_grant[i] = req_access[i];
          end
        end
      end
      default: begin
        w_grant = '0;
      end
    endcase

    for (int unsigned i = 0; i < NR; i++) begin
      if (w_grant[i]) begin
        w_acc_packet = req_packet[i*PW +: PW];
        w_acc_lock   = req_lock[i];
      end
    end

    w_accept  = (|w_grant) && !reset;
    w_idx_inc = (w_idx == IDW'(NR-1)) ? '0 : w_idx + 1'b1;

    if (w_accept) begin
      case (r_state)
        ST_IDLE: begin
          w_rr_ptr_nxt = w_idx_inc;
          if (w_acc_lock) begin
            w_state_nxt = ST_LOCKED;
            w_owner_nxt = w_idx;
          end
        end
        ST_LOCKED: begin
          if (!w_acc_lock) begin
            w_state_nxt  = ST_IDLE;
            w_rr_ptr_nxt = w_idx_inc;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end

    req_wait = reset ? '1 : ~w_grant;
  end

  // Lock state, lock owner and round-robin pointer registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_owner  <= '0;
      r_rr_ptr <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_owner  <= w_owner_nxt;
      r_rr_ptr <= w_rr_ptr_nxt;
    end
  end

  // Access output stage: pulse gpio_access per acceptance, packet holds between.
  always_ff @(posedge clk) begin
    if (reset) begin
      gpio_access <= 1'b0;
      gpio_packet <= '0;
    end else begin
      gpio_access <= w_accept;
      if (w_accept) begin
        gpio_packet <= w_acc_packet;
      end
    end
  end

  // Decode the oldest return-pipe slot into a one-hot master strobe.
  always_comb begin
    w_rsp_onehot = '0;
    for (int unsigned i = 0; i < NR; i++) begin
      w_rsp_onehot[i] = r_ret_rd[RET_DEPTH-1] &&
                        (r_ret_idx[RET_DEPTH-1] == IDW'(i));
    end
  end

  // Return pipe: shift {is_read, idx} so gpio_rdata is captured the cycle it is valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned k = 0; k < RET_DEPTH; k++) begin
        r_ret_rd[k]  <= 1'b0;
        r_ret_idx[k] <= '0;
      end
      rsp_valid <= '0;
      rsp_data  <= '0;
    end else begin
      r_ret_rd[0]  <= w_accept && !w_acc_packet[WRITE_BIT];
      r_ret_idx[0] <= w_idx;
      for (int unsigned k = 1; k < RET_DEPTH; k++) begin
        r_ret_rd[k]  <= r_ret_rd[k-1];
        r_ret_idx[k] <= r_ret_idx[k-1];
      end
      rsp_valid <= w_rsp_onehot;
      if (r_ret_rd[RET_DEPTH-1]) begin
        rsp_data <= gpio_rdata;
      end
    end
  end

endmodule

// File: tb/tb_gpio_reg_arb.sv
// Bench for gpio_reg_arb: directed scenarios plus random traffic, all checked
// against a transaction-level reference model with a pending-read queue.
module tb_gpio_reg_arb;

  localparam int NR  = 3;
  localparam int AW  = 32;
  localparam int PW  = 2*AW+40;
  localparam int IDW = 3;

  logic             clk = 1'b0;
  logic             reset;
  logic [NR-1:0]    req_access;
  logic [NR-1:0]    req_lock;
  logic [NR*PW-1:0] req_packet;
  logic [NR-1:0]    req_wait;
  logic [NR-1:0]    rsp_valid;
  logic [31:0]      rsp_data;
  logic             gpio_access;
  logic [PW-1:0]    gpio_packet;
  logic [31:0]      gpio_rdata;

  always #5 clk = ~clk;

  gpio_reg_arb #(
    .NR  (NR),
    .AW  (AW),
    .PW  (PW),
    .IDW (IDW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_access  (req_access),
    .req_lock    (req_lock),
    .req_packet  (req_packet),
    .req_wait    (req_wait),
    .rsp_valid   (rsp_valid),
    .rsp_data    (rsp_data),
    .gpio_access (gpio_access),
    .gpio_packet (gpio_packet),
    .gpio_rdata  (gpio_rdata)
  );

  int errors = 0;
  int checks = 0;

  task automatic check_val(input string tag, input logic [127:0] got,
                           input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model state
  typedef struct { int due; int idx; } rd_t;
  rd_t           pend[$];
  bit            m_locked = 1'b0;
  int            m_owner  = 0;
  int            m_ptr    = 0;
  logic          m_acc    = 1'b0;
  logic [PW-1:0] m_pkt    = '0;
  logic [NR-1:0] m_rsp    = '0;
  logic [31:0]   m_rdata  = '0;
  int            cyc      = 0;
  int            last_grant;

  function automatic logic [PW-1:0] mkpkt(input logic wr);
    logic [127:0] t;
    t    = {$urandom, $urandom, $urandom, $urandom};
    t[0] = wr;
    return t[PW-1:0];
  endfunction

  // Compare current outputs with the model, then advance the model by one cycle.
  task automatic step();
    int            g;
    logic [NR-1:0] ew;
    logic [PW-1:0] pk;
    g = -1;
    if (!reset) begin
      if (m_locked) begin
        if (req_access[m_owner]) g = m_owner;
      end else begin
        for (int k = 0; k < NR; k++) begin
          int j;
          j = (m_ptr + k) % NR;
          if (g < 0 && req_access[j]) g = j;
        end
      end
    end
    ew = '1;
    if (g >= 0) ew[g] = 1'b0;
    check_val("req_wait",    req_wait,    ew);
    check_val("gpio_access", gpio_access, m_acc);
    check_val("gpio_packet", gpio_packet, m_pkt);
    check_val("rsp_valid",   rsp_valid,   m_rsp);
    check_val("rsp_data",    rsp_data,    m_rdata);
    last_grant = g;

    if (reset) begin
      pend.delete();
      m_locked = 1'b0;
      m_ptr    = 0;
      m_acc    = 1'b0;
      m_pkt    = '0;
      m_rsp    = '0;
      m_rdata  = '0;
    end else begin
      m_rsp = '0;
      if (pend.size() > 0 && pend[0].due == cyc + 1) begin
        m_rsp[pend[0].idx] = 1'b1;
        m_rdata = gpio_rdata;
        void'(pend.pop_front());
      end
      m_acc = (g >= 0);
      if (g >= 0) begin
        pk    = req_packet[g*PW +: PW];
        m_pkt = pk;
        if (!pk[0]) pend.push_back('{cyc + 3, g});
        if (!m_locked) begin
          m_ptr = (g + 1) % NR;
          if (req_lock[g]) begin
            m_locked = 1'b1;
            m_owner  = g;
          end
        end else if (!req_lock[g]) begin
          m_locked = 1'b0;
          m_ptr    = (g + 1) % NR;
        end
      end
    end
    cyc++;
  endtask

  // One clock: drive inputs after the edge, then check/model at the falling edge.
  task automatic run_cycle(input logic rst, input logic [NR-1:0] acc,
                           input logic [NR-1:0] lk, input logic [NR-1:0] wr,
                           input logic [31:0] rd);
    @(posedge clk);
    #1;
    reset      = rst;
    req_access = acc;
    req_lock   = lk;
    for (int i = 0; i < NR; i++) req_packet[i*PW +: PW] = mkpkt(wr[i]);
    gpio_rdata = rd;
    @(negedge clk);
    step();
  endtask

  initial begin
    reset      = 1'b1;
    req_access = '0;
    req_lock   = '0;
    req_packet = '0;
    gpio_rdata = '0;

    // reset and idle
    repeat (3) run_cycle(1'b1, 3'b000, 3'b000, 3'b000, $urandom);
    repeat (2) run_cycle(1'b0, 3'b000, 3'b000, 3'b000, $urandom);

    // single write from master0
    run_cycle(1'b0, 3'b001, 3'b000, 3'b001, $urandom);
    check_val("wr_wait0", req_wait[0], 1'b0);
    run_cycle(1'b0, 3'b000, 3'b000, 3'b000, $urandom);
    check_val("wr_access", gpio_access, 1'b1);
    repeat (3) begin
      run_cycle(1'b0, 3'b000, 3'b000, 3'b000, $urandom);
      check_val("wr_no_rsp", rsp_valid, 3'b000);
    end

    // single read from master1, data presented two cycles later
    run_cycle(1'b0, 3'b010, 3'b000, 3'b000, $urandom);
    run_cycle(1'b0, 3'b000, 3'b000, 3'b000, $urandom);
    run_cycle(1'b0, 3'b000, 3'b000, 3'b000, 32'h0012_3456);
    run_cycle(1'b0, 3'b000, 3'b000, 3'b000, $urandom);
    check_val("rd_valid", rsp_valid, 3'b010);
    check_val("rd_data",  rsp_data,  32'h0012_3456);
    run_cycle(1'b0, 3'b000, 3'b000, 3'b000, $urandom);
    check_val("rd_pulse", rsp_valid, 3'b000);

    // fairness from rr_ptr=0
    run_cycle(1'b1, 3'b000, 3'b000, 3'b000, $urandom);
    for (int k = 0; k < 6; k++) begin
      int obs;
      run_cycle(1'b0, 3'b111, 3'b000, 3'($urandom), $urandom);
      obs = -1;
      for (int i = 0; i < NR; i++) if (!req_wait[i]) obs = i;
      check_val("rr_order", obs, k % NR);
    end
    repeat (3) run_cycle(1'b0, 3'b000, 3'b000, 3'b000, $urandom);

    // lock held by master0 across a read-modify-write
    run_cycle(1'b0, 3'b001, 3'b001, 3'b000, $urandom);
    for (int k = 0; k < 3; k++) begin
      run_cycle(1'b0, 3'b010, 3'b000, 3'b000, $urandom);
      check_val("lock_stall1", req_wait[1], 1'b1);
    end
    run_cycle(1'b0, 3'b011, 3'b000, 3'b001, $urandom);
    check_val("lock_stall1_rel", req_wait[1], 1'b1);
    check_val("lock_owner_go",   req_wait[0], 1'b0);
    run_cycle(1'b0, 3'b010, 3'b000, 3'b001, $urandom);
    check_val("lock_after", req_wait[1], 1'b0);
    repeat (3) run_cycle(1'b0, 3'b000, 3'b000, 3'b000, $urandom);

    // back-to-back reads
    run_cycle(1'b0, 3'b001, 3'b000, 3'b000, $urandom);
    run_cycle(1'b0, 3'b010, 3'b000, 3'b000, $urandom);
    run_cycle(1'b0, 3'b000, 3'b000, 3'b000, 32'hAAAA_0001);
    run_cycle(1'b0, 3'b000, 3'b000, 3'b000, 32'hBBBB_0002);
    check_val("b2b_v0", rsp_valid, 3'b001);
    check_val("b2b_d0", rsp_data,  32'hAAAA_0001);
    run_cycle(1'b0, 3'b000, 3'b000, 3'b000, $urandom);
    check_val("b2b_v1", rsp_valid, 3'b010);
    check_val("b2b_d1", rsp_data,  32'hBBBB_0002);

    // reset during an in-flight locked read
    run_cycle(1'b0, 3'b100, 3'b100, 3'b000, $urandom);
    run_cycle(1'b1, 3'b100, 3'b100, 3'b000, $urandom);
    run_cycle(1'b0, 3'b001, 3'b000, 3'b001, $urandom);
    check_val("rst_access", gpio_access, 1'b0);
    check_val("rst_unlock", req_wait[0], 1'b0);
    for (int k = 0; k < 4; k++) begin
      run_cycle(1'b0, 3'b000, 3'b000, 3'b000, $urandom);
      check_val("rst_no_rsp", rsp_valid, 3'b000);
    end

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      logic          r;
      logic [NR-1:0] a;
      logic [NR-1:0] l;
      r = ($urandom % 64) == 0;
      a = NR'($urandom);
      l = (($urandom % 4) == 0) ? NR'($urandom) : '0;
      run_cycle(r, a, l, NR'($urandom), $urandom);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
